// File: rtl/defines_pkg.sv
// defines_pkg: shared constants, writeback payload type and skid buffer state encoding.
package defines_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic [4:0] RegNopAddr = 5'b0;
  typedef struct packed {
    logic [4:0] wd;
    logic wreg;
    logic [31:0] wdata;
    logic whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } wb_payload_t;
  // The encoding is {skid_valid, main_valid}; 2'b10 can never be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL = 2'b01,
    ST_SKID = 2'b11
  } state_t;
endpackage

// File: rtl/pipe_stage_skid_skid.sv
// skid_reg: generic W-bit 2-entry skid buffer with valid/ready handshake and flush.
module skid_reg
  import defines_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  state_t st, st_n;
  logic [W-1:0] main_q, skid_q;
  logic in_acc, out_acc;
  assign in_ready = st != ST_SKID;
  assign out_valid = st[0];
  assign out_data = main_q;
  assign in_acc = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;
  always_ff @(posedge clk) st <= (rst == RstEnable) ? ST_EMPTY : st_n;
  always_comb begin
    st_n = st;
    case (st)
      ST_EMPTY: st_n = in_acc ? ST_FULL : ST_EMPTY;
      ST_FULL:  st_n = (in_acc & !out_acc) ? ST_SKID : (!in_acc & out_acc) ? ST_EMPTY : ST_FULL;
      ST_SKID:  st_n = out_acc ? ST_FULL : ST_SKID;
      default:  st_n = ST_EMPTY;
    endcase
    if (flush) st_n = ST_EMPTY;
  end
  // A main load while draining to EMPTY captures don't-care data; the state masks it.
  always_ff @(posedge clk) begin
    if (out_acc | (in_acc & !out_valid)) main_q <= (st == ST_SKID) ? skid_q : in_data;
    if ((st == ST_FULL) & in_acc & !out_acc) skid_q <= in_data;
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: writeback-payload stage register with skid buffer and NOP gating.
// Optional bubble counter is enabled by defining BUBBLE_CNT_EN.
module pipe_stage_skid
  import defines_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
`ifdef BUBBLE_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_whilo,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_whilo,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo
`ifdef BUBBLE_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);
  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic wreg;
    logic [DATA_W-1:0] wdata;
    logic whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } payload_t;
  payload_t din, q;
  assign din = '{in_wd, in_wreg, in_wdata, in_whilo, in_hi, in_lo};
  skid_reg #(.W($bits(payload_t))) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(q)
  );
  // An empty stage presents a NOP so the next stage sees the classic bubble.
  assign out_wd = out_valid ? q.wd : '0;
  assign out_wreg = out_valid ? q.wreg : WriteDisable;
  assign out_wdata = out_valid ? q.wdata : '0;
  assign out_whilo = out_valid ? q.whilo : WriteDisable;
  assign out_hi = out_valid ? q.hi : '0;
  assign out_lo = out_valid ? q.lo : '0;
`ifdef BUBBLE_CNT_EN
  always_ff @(posedge clk)
    if (rst == RstEnable) bubble_cnt <= '0;
    else if (!out_valid & out_ready & !flush & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed plus random stimulus against a queue-based stage model.
module tb_pipe_stage_skid;
  typedef struct packed {
    logic [4:0] wd;
    logic wreg;
    logic [31:0] wdata;
    logic whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } pl_t;
  logic clk = 0, rst, flush, in_valid, in_ready, in_wreg, in_whilo, out_valid, out_ready;
  logic out_wreg, out_whilo;
  logic [4:0] in_wd, out_wd;
  logic [31:0] in_wdata, in_hi, in_lo, out_wdata, out_hi, out_lo;
  int checks = 0, errors = 0, dut_pops = 0, cnt = 0;
  pl_t q[$];
`ifdef BUBBLE_CNT_EN
  logic [1:0] bubble_cnt;
`endif
  always #5 clk = ~clk;
  pipe_stage_skid #(.DATA_W(32), .ADDR_W(5)
`ifdef BUBBLE_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_whilo(in_whilo),
    .in_hi(in_hi), .in_lo(in_lo), .out_valid(out_valid), .out_ready(out_ready),
    .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata), .out_whilo(out_whilo),
    .out_hi(out_hi), .out_lo(out_lo)
`ifdef BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] wd, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    in_valid = v; in_wd = wd; in_wreg = 1'b1; in_wdata = wdata; in_whilo = whilo; in_hi = hi; in_lo = lo;
  endtask
  // Model: the stage is a FIFO of depth 2 whose ready reflects occupancy at the cycle start.
  task automatic step();
    bit ia, oa, bub;
    pl_t exp, d;
    exp = (q.size() != 0) ? q[0] : '0;
    d = '{in_wd, in_wreg, in_wdata, in_whilo, in_hi, in_lo};
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("payload", {out_wd, out_wreg, out_wdata, out_whilo, out_hi, out_lo}, exp);
`ifdef BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt, cnt);
`endif
    if (out_valid && out_ready) dut_pops++;
    ia = in_valid && q.size() < 2;
    oa = q.size() != 0 && out_ready;
    bub = q.size() == 0 && out_ready && !flush;
    @(posedge clk);
    #1;
    if (rst) cnt = 0;
    else if (bub && cnt < 3) cnt++;
    if (rst || flush) q.delete();
    else begin
      if (oa) void'(q.pop_front());
      if (ia) q.push_back(d);
    end
  endtask
  initial begin
    int p0;
    rst = 1; flush = 0; out_ready = 1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    step();
    chk("reset_wd", out_wd, 0);
    chk("reset_wdata", out_wdata, 0);
    chk("reset_whilo", out_whilo, 0);
    drive(1, 5, 32'h1234_5678, 1, 32'hA, 32'hB);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("stream_wd", out_wd, 5);
    chk("stream_wdata", out_wdata, 32'h1234_5678);
    chk("stream_hilo", {out_whilo, out_hi, out_lo}, {1'b1, 32'hA, 32'hB});
    step();
    p0 = dut_pops;
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(i + 8), $urandom, i[0], $urandom, $urandom);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("b2b_9cyc", dut_pops - p0, 8);
    out_ready = 0;
    drive(1, 1, 32'h11, 0, 0, 0);
    step();
    drive(1, 2, 32'h22, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("bp_ready", in_ready, 0);
    chk("bp_hold", out_wd, 1);
    step();
    chk("bp_hold2", out_wd, 1);
    out_ready = 1;
    step();
    chk("bp_next", out_wd, 2);
    step();
    chk("bp_drain", in_ready, 1);
    out_ready = 0;
    drive(1, 1, 1, 0, 0, 0);
    step();
    drive(1, 2, 2, 0, 0, 0);
    step();
    flush = 1;
    drive(1, 7, 7, 1, 7, 7);
    step();
    flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_wreg", out_wreg, 0);
    chk("flush_ready", in_ready, 1);
    step();
    drive(1, 3, 3, 0, 0, 0);
    step();
    out_ready = 1;
    drive(1, 4, 4, 0, 0, 0);
    step();
    out_ready = 0;
    drive(0, 0, 0, 0, 0, 0);
    chk("sim_wd", out_wd, 4);
    chk("sim_noskid", in_ready, 1);
    step();
`ifdef BUBBLE_CNT_EN
    rst = 1;
    step();
    rst = 0;
    out_ready = 1;
    repeat (5) step();
    chk("bubble_sat", bubble_cnt, 3);
`endif
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
      in_wreg = 1'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed EX/MEM stage register. It carries the writeback payload between two pipeline stages: destination register address, write enable, result data, and the HI/LO pair plus its write enable. The global stall vector is replaced by a per-stage valid/ready handshake. A 2-entry skid buffer keeps full throughput while in_ready stays a registered signal. Every stage boundary (ID/EX, EX/MEM, MEM/WB) instantiates it.

Parameters:
DATA_W, 32, width of wdata, hi, lo
ADDR_W, 5, width of register address
CNT_W, 16, width of bubble counter (used only with BUBBLE_CNT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries (exception/branch kill)
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_wd  in  ADDR_W  destination register
in_wreg  in  1  register write enable
in_wdata  in  DATA_W  result
in_whilo  in  1  HI/LO write enable
in_hi  in  DATA_W  HI value
in_lo  in  DATA_W  LO value
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_wd, out_wreg, out_wdata, out_whilo, out_hi, out_lo  out  as inputs  registered payload
bubble_cnt  out  CNT_W  present only with BUBBLE_CNT_EN

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: out_valid=0, in_ready=1, all payload outputs 0, bubble_cnt=0.
- Storage: main register drives the outputs; skid register holds overflow. Payload width is ADDR_W+2+3*DATA_W.
- in_acc = in_valid & in_ready. out_acc = out_valid & out_ready.
- States are encoded by {skid_valid, main_valid}:
  - EMPTY (00):
    - in_acc: load main, go to FULL.
  - FULL (01):
    - in_acc & out_acc: reload main, stay in FULL.
    - in_acc & !out_acc: write skid, go to SKID.
    - !in_acc & out_acc: go to EMPTY.
  - SKID (11): in_ready=0.
    - out_acc: move skid into main, clear skid, go to FULL.
  - State 10 is unreachable.
- Latency: one cycle from in_acc in EMPTY to out_valid=1. Throughput is one transfer per cycle in FULL when both sides are ready.
- Order is strict FIFO. No payload is ever dropped or duplicated without flush.
- Bubble rule: whenever out_valid=0, out_wreg and out_whilo are forced to 0 and every other payload output reads 0. A NOP reaches the next stage, matching the old stalled-stage bubble.
- Payload is held unchanged while out_valid=1 & out_ready=0.
- flush: next cycle both entries are invalid, in_ready=1 and outputs show the bubble. A simultaneous in_valid is discarded. flush has priority over any in_acc or out_acc.
- rst mid-transfer behaves exactly as flush and additionally clears bubble_cnt.
- There are no arithmetic operations on the payload; fields pass through bit-exact.

Optional Feature:
BUBBLE_CNT_EN:
- Defined: bubble_cnt increments each cycle with out_valid=0 & out_ready=1 & !flush, and saturates at 2^CNT_W-1. It resets only on rst.
- Undefined: the bubble_cnt port and its logic do not exist, and CNT_W is unused.

Decomposition:
- The shared package defines_pkg holds:
  - Reset/enable constants: RstEnable, WriteEnable/WriteDisable, ZeroWord, RegNopAddr.
  - A typedef wb_payload_t bundling {wd, wreg, wdata, whilo, hi, lo}.
  - The state encoding constants ST_EMPTY, ST_FULL, ST_SKID.
- One natural sub-module is skid_reg: a generic width-W 2-entry skid buffer with valid/ready and flush. pipe_stage_skid wraps it with packing/unpacking and the bubble-gating logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → out_valid=0, in_ready=1, out_wd=0, out_wdata=0, out_whilo=0.
- Streaming: send wd=5, wdata=0x1234_5678, whilo=1, hi=0xA, lo=0xB with out_ready=1 → identical values on outputs one cycle later. Back-to-back 8 transfers complete in 9 cycles.
- Backpressure: out_ready=0 and push 2 items (wd=1, wd=2) → in_ready=0 after the second. out_wd holds 1 until out_ready=1, then 2 appears the next cycle, and in_ready=1 the cycle after the skid drains.
- Flush in SKID: two entries held, assert flush with in_valid=1, wd=7 → next cycle out_valid=0, out_wreg=0, in_ready=1; wd=7 never appears.
- Simultaneous accept/consume in FULL: main wd=3, push wd=4 with out_ready=1 → next cycle out_wd=4, skid stays empty.
- BUBBLE_CNT_EN, CNT_W=2: hold out_valid=0 with out_ready=1 for 5 cycles → bubble_cnt reads 3 (saturated).
